// File: rtl/key_event_gen.sv
// key_event_gen: converts a debounced key level into press/release/repeat
// events, a held/long-press level pair and a wrapping 8-bit event counter.
// One instance per key, fed directly by the debouncer in the same clock domain.
module key_event_gen #(
    parameter int unsigned HOLD_TIME_LOG   = 20,
    parameter int unsigned REPEAT_TIME_LOG = 18,
    parameter int unsigned ACTIVE_HIGH     = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       key,
    input  logic       repeat_en,
    output logic       pressed,
    output logic       long_press,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       repeat_pulse,
    output logic [7:0] event_cnt
);

    typedef enum logic [2:0] {
        INIT,
        LOCKED,
        IDLE,
        HOLD,
        REPEAT
    } state_t;

    state_t                   state;
    logic [HOLD_TIME_LOG-1:0] cnt;
    logic                     act;

    // Normalise key polarity so the FSM always sees 1 = pressed.
    always_comb begin
        act = (ACTIVE_HIGH != 0) ? key : ~key;
    end

    // Key-event FSM with hold/repeat timer; all outputs registered.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= INIT;
            cnt           <= '0;
            pressed       <= 1'b0;
            long_press    <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
            event_cnt     <= '0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
            case (state)
                INIT: begin
                    // A key already down when reset lifts must be released first.
                    state <= act ? LOCKED : IDLE;
                end
                LOCKED: begin
                    if (!act) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (act) begin
                        state       <= HOLD;
                        cnt         <= '0;
                        press_pulse <= 1'b1;
                        pressed     <= 1'b1;
                        event_cnt   <= event_cnt + 8'd1;
                    end
                end
                HOLD: begin
                    if (!act) begin
                        state         <= IDLE;
                        release_pulse <= 1'b1;
                        pressed       <= 1'b0;
                    end else if (cnt == '1) begin
                        state        <= REPEAT;
                        cnt          <= '0;
                        long_press   <= 1'b1;
                        repeat_pulse <= repeat_en;
                        if (repeat_en) begin
                            event_cnt <= event_cnt + 8'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!act) begin
                        state         <= IDLE;
                        release_pulse <= 1'b1;
                        pressed       <= 1'b0;
                        long_press    <= 1'b0;
                    end else if (cnt[REPEAT_TIME_LOG-1:0] == '1) begin
                        cnt          <= '0;
                        repeat_pulse <= repeat_en;
                        if (repeat_en) begin
                            event_cnt <= event_cnt + 8'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_event_gen.sv
// Directed testbench for key_event_gen with short hold/repeat times.
module tb_key_event_gen;

    logic       clock;
    logic       reset_n;
    logic       key;
    logic       repeat_en;
    logic       pressed;
    logic       long_press;
    logic       press_pulse;
    logic       release_pulse;
    logic       repeat_pulse;
    logic [7:0] event_cnt;

    int tests;
    int fails;

    key_event_gen #(
        .HOLD_TIME_LOG  (4),
        .REPEAT_TIME_LOG(2),
        .ACTIVE_HIGH    (1)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .key          (key),
        .repeat_en    (repeat_en),
        .pressed      (pressed),
        .long_press   (long_press),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .repeat_pulse (repeat_pulse),
        .event_cnt    (event_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".pressed"}, {7'd0, pressed}, 8'd0);
        check({tag, ".long"}, {7'd0, long_press}, 8'd0);
        check({tag, ".press"}, {7'd0, press_pulse}, 8'd0);
        check({tag, ".release"}, {7'd0, release_pulse}, 8'd0);
        check({tag, ".repeat"}, {7'd0, repeat_pulse}, 8'd0);
        check({tag, ".evcnt"}, event_cnt, 8'd0);
    endtask

    task automatic do_reset(input logic key_level);
        key     = key_level;
        reset_n = 1'b0;
        #12;
        check_all_zero("reset");
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        key       = 1'b0;
        repeat_en = 1'b1;
        reset_n   = 1'b0;

        // 1: simple press
        do_reset(1'b0);
        tick();
        key = 1'b1;
        tick();
        check("t1.press", {7'd0, press_pulse}, 8'd1);
        check("t1.pressed", {7'd0, pressed}, 8'd1);
        check("t1.evcnt", event_cnt, 8'd1);

        // 2: hold 30 cycles with repeat enabled
        for (int k = 1; k <= 30; k++) begin
            tick();
            check("t2.press", {7'd0, press_pulse}, 8'd0);
            check("t2.repeat", {7'd0, repeat_pulse},
                  (k == 16 || k == 20 || k == 24 || k == 28) ? 8'd1 : 8'd0);
            check("t2.long", {7'd0, long_press}, (k >= 16) ? 8'd1 : 8'd0);
            check("t2.pressed", {7'd0, pressed}, 8'd1);
        end
        check("t2.evcnt", event_cnt, 8'd5);
        key = 1'b0;
        tick();
        check("t2.release", {7'd0, release_pulse}, 8'd1);
        check("t2.pressed_off", {7'd0, pressed}, 8'd0);
        check("t2.long_off", {7'd0, long_press}, 8'd0);
        tick();
        check("t2.release_once", {7'd0, release_pulse}, 8'd0);
        check("t2.evcnt_end", event_cnt, 8'd5);

        // 3: hold with repeat disabled
        do_reset(1'b0);
        repeat_en = 1'b0;
        tick();
        key = 1'b1;
        tick();
        check("t3.press", {7'd0, press_pulse}, 8'd1);
        for (int k = 1; k <= 22; k++) begin
            tick();
            check("t3.repeat", {7'd0, repeat_pulse}, 8'd0);
            check("t3.long", {7'd0, long_press}, (k >= 16) ? 8'd1 : 8'd0);
        end
        check("t3.evcnt", event_cnt, 8'd1);
        key = 1'b0;
        tick();
        check("t3.release", {7'd0, release_pulse}, 8'd1);
        repeat_en = 1'b1;

        // 4: key held through reset release
        do_reset(1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t4.nopress", {7'd0, press_pulse}, 8'd0);
            check("t4.nopressed", {7'd0, pressed}, 8'd0);
        end
        check("t4.evcnt0", event_cnt, 8'd0);
        key = 1'b0;
        tick();
        check("t4.idle", {7'd0, press_pulse}, 8'd0);
        key = 1'b1;
        tick();
        check("t4.press", {7'd0, press_pulse}, 8'd1);
        check("t4.evcnt1", event_cnt, 8'd1);

        // 5: release exactly when hold timer would expire
        do_reset(1'b0);
        tick();
        key = 1'b1;
        tick();
        check("t5.press", {7'd0, press_pulse}, 8'd1);
        repeat (15) tick();
        key = 1'b0;
        tick();
        check("t5.release", {7'd0, release_pulse}, 8'd1);
        check("t5.norepeat", {7'd0, repeat_pulse}, 8'd0);
        check("t5.nolong", {7'd0, long_press}, 8'd0);
        check("t5.pressed", {7'd0, pressed}, 8'd0);
        tick();
        check("t5.idle_repeat", {7'd0, repeat_pulse}, 8'd0);
        check("t5.evcnt", event_cnt, 8'd1);

        // 6: counter wrap, then async reset mid-REPEAT
        do_reset(1'b0);
        tick();
        for (int k = 0; k < 260; k++) begin
            key = 1'b1;
            tick();
            key = 1'b0;
            tick();
        end
        check("t6.wrap", event_cnt, 8'd4);
        key = 1'b1;
        repeat (18) tick();
        check("t6.long", {7'd0, long_press}, 8'd1);
        check("t6.evcnt", event_cnt, 8'd6);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("t6.async");
        reset_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
